// File: rtl/sd_stream_pkg.sv
// Shared types for the SD-to-audio-FIFO stream scheduler.
package sd_stream_pkg;

  localparam int SD_BLOCK_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SPACE,
    ST_WAIT_READY,
    ST_ISSUE,
    ST_RECEIVE,
    ST_NEXT,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/sd_stream_scheduler_rise_detect.sv
// One-bit rising-edge detector: remembers last cycle's level, flags 0->1 transitions.
module rise_detect (
  input  logic clk_25mhz,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/sd_stream_scheduler.sv
// Sequences sector reads from an SD controller into an external audio FIFO,
// waiting for a block's worth of FIFO space before each read.
module sd_stream_scheduler
  import sd_stream_pkg::*;
#(
  parameter int FIFO_DEPTH  = 1024,
  parameter int BLOCK_BYTES = SD_BLOCK_BYTES
) (
  input  logic                        clk_25mhz,
  input  logic                        rst,
  input  logic                        play,
  input  logic                        stop,
  input  logic [31:0]                 start_sector,
  input  logic [15:0]                 num_sectors,
  input  logic                        sd_ready,
  input  logic                        sd_byte_available,
  input  logic [7:0]                  sd_dout,
  output logic                        sd_rd,
  output logic [31:0]                 sd_address,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_data_count,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [7:0]                  fifo_din,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
  output state_t                      state_dbg
);

  // Handshakes: sd_rd is a one-cycle request raised only after sd_ready was seen
  // high; each SD byte is qualified by a 0->1 edge of sd_byte_available; the FIFO
  // has no back-pressure, so fifo_wr_en is a strobe that fifo_full can only veto.

  localparam int BW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

  state_t          state, state_nxt;
  logic [31:0]     start_q;
  logic [15:0]     num_q;
  logic [15:0]     sector_idx;
  logic [BW-1:0]   byte_cnt;
  logic            blk_done;
  logic            byte_rise;

  logic play_ok, has_space, last_sector, in_block, counting, last_byte, write_due;

  assign play_ok     = play && !stop;
  assign has_space   = (32'(fifo_data_count) + 32'(BLOCK_BYTES)) <= 32'(FIFO_DEPTH);
  assign last_sector = (sector_idx == num_q - 16'd1);
  assign in_block    = (state == ST_RECEIVE) || (state == ST_DRAIN);
  assign counting    = in_block && !blk_done;
  assign last_byte   = (byte_cnt == BW'(BLOCK_BYTES - 1));
  assign write_due   = byte_rise && counting && (state == ST_RECEIVE) && !stop;

  rise_detect u_rise (
    .clk_25mhz (clk_25mhz),
    .rst       (rst),
    .d         (sd_byte_available),
    .rise      (byte_rise)
  );

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // blk_done holds RECEIVE one extra cycle so the last byte's write stays inside it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (play_ok && num_sectors != 16'd0) state_nxt = ST_WAIT_SPACE;
      ST_WAIT_SPACE: if (stop) state_nxt = ST_IDLE;
                     else if (has_space) state_nxt = ST_WAIT_READY;
      ST_WAIT_READY: if (stop) state_nxt = ST_IDLE;
                     else if (sd_ready) state_nxt = ST_ISSUE;
      ST_ISSUE:      state_nxt = stop ? ST_DRAIN : ST_RECEIVE;
      ST_RECEIVE:    if (stop) state_nxt = ST_DRAIN;
                     else if (blk_done) state_nxt = ST_NEXT;
      ST_NEXT:       state_nxt = (last_sector || stop) ? ST_IDLE : ST_WAIT_SPACE;
      ST_DRAIN:      if (blk_done) state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    sd_rd     = (state == ST_ISSUE);
    state_dbg = state;
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      start_q    <= '0;
      num_q      <= '0;
      sector_idx <= '0;
      byte_cnt   <= '0;
      blk_done   <= 1'b0;
      sd_address <= '0;
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done       <= 1'b0;
      fifo_wr_en <= 1'b0;

      if (state == ST_IDLE && play_ok) begin
        overflow <= 1'b0;
        if (num_sectors == 16'd0) begin
          done <= 1'b1;
        end else begin
          start_q    <= start_sector;
          num_q      <= num_sectors;
          sector_idx <= '0;
        end
      end

      if (state == ST_WAIT_READY && sd_ready && !stop)
        sd_address <= start_q + 32'(sector_idx);

      if (state == ST_NEXT) begin
        if (last_sector) done <= 1'b1;
        else             sector_idx <= sector_idx + 16'd1;
      end

      if (counting && byte_rise) begin
        byte_cnt <= last_byte ? '0 : byte_cnt + BW'(1);
        blk_done <= last_byte;
      end else if (!in_block) begin
        byte_cnt <= '0;
        blk_done <= 1'b0;
      end

      // A byte arriving while the FIFO is full is still counted, just not written.
      if (write_due) begin
        fifo_din <= sd_dout;
        if (fifo_full) overflow   <= 1'b1;
        else           fifo_wr_en <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_stream_scheduler.sv
// Directed bench for sd_stream_scheduler: SD byte source, FIFO-level driver, output monitor.
module tb_sd_stream_scheduler;
  import sd_stream_pkg::*;

  logic        clk_25mhz = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] start_sector = '0;
  logic [15:0] num_sectors = '0;
  logic        sd_ready = 1'b1;
  logic        sd_byte_available = 1'b0;
  logic [7:0]  sd_dout = '0;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [10:0] fifo_data_count = '0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_en;
  logic [7:0]  fifo_din;
  logic        busy;
  logic        done;
  logic        overflow;
  state_t      state_dbg;

  int checks = 0;
  int passes = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] addr_q[$];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, viol_cnt = 0;

  sd_stream_scheduler #(.FIFO_DEPTH(1024), .BLOCK_BYTES(512)) dut (
    .clk_25mhz         (clk_25mhz),
    .rst               (rst),
    .play              (play),
    .stop              (stop),
    .start_sector      (start_sector),
    .num_sectors       (num_sectors),
    .sd_ready          (sd_ready),
    .sd_byte_available (sd_byte_available),
    .sd_dout           (sd_dout),
    .sd_rd             (sd_rd),
    .sd_address        (sd_address),
    .fifo_data_count   (fifo_data_count),
    .fifo_full         (fifo_full),
    .fifo_wr_en        (fifo_wr_en),
    .fifo_din          (fifo_din),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .state_dbg         (state_dbg)
  );

  // ---- clock ----
  always #20 clk_25mhz = ~clk_25mhz;

  // ---- monitor: records writes, reads, done pulses away from the active edge ----
  always @(negedge clk_25mhz) begin
    if (fifo_wr_en) begin
      got_q.push_back(fifo_din);
      wr_cnt++;
      if (state_dbg != ST_RECEIVE) viol_cnt++;
    end
    if (sd_rd) begin
      addr_q.push_back(sd_address);
      rd_cnt++;
      if (state_dbg != ST_ISSUE) viol_cnt++;
    end
    if (done) done_cnt++;
  end

  // ---- driver tasks ----
  task automatic tick(input int n);
    repeat (n) @(posedge clk_25mhz);
    #1;
  endtask

  task automatic pulse_play(input logic [31:0] s, input logic [15:0] n, input logic with_stop);
    start_sector = s;
    num_sectors  = n;
    play = 1'b1;
    stop = with_stop;
    tick(1);
    play = 1'b0;
    stop = 1'b0;
  endtask

  function automatic logic [7:0] model_byte(input logic [31:0] addr, input int i);
    logic [7:0] b;
    b = 8'(i * 5 + 3);
    return b ^ addr[7:0] ^ 8'(i >> 8);
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic full);
    sd_dout = d;
    sd_byte_available = 1'b1;
    fifo_full = full;
    tick(1);
    sd_byte_available = 1'b0;
    fifo_full = 1'b0;
    tick(1);
  endtask

  // Bytes with index in [drop_lo, drop_hi] arrive while the FIFO reports full.
  task automatic serve(input logic [31:0] addr, input int first, input int count,
                       input int drop_lo, input int drop_hi, input bit expect_wr);
    for (int i = first; i < first + count; i++) begin
      logic [7:0] d;
      logic full;
      d = model_byte(addr, i);
      full = (i >= drop_lo) && (i <= drop_hi);
      if (expect_wr && !full) exp_q.push_back(d);
      send_byte(d, full);
    end
  endtask

  task automatic wait_rd(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_25mhz);
      if (sd_rd) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int stream_errors(input int eb, input int gb);
    int errs;
    errs = 0;
    if (got_q.size() - gb != exp_q.size() - eb) return 1 + (got_q.size() - gb);
    for (int i = 0; i < exp_q.size() - eb; i++)
      if (got_q[gb + i] !== exp_q[eb + i]) errs++;
    return errs;
  endfunction

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++;
    if ({busy, done, overflow, sd_rd, fifo_wr_en} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {busy, done, overflow, sd_rd, fifo_wr_en});
    else passes++;
    checks++;
    if (sd_address !== 32'h0 || fifo_din !== 8'h0 || state_dbg !== ST_IDLE)
      $display("FAIL reset_regs: got addr=%0h din=%0h state=%0d expected 0/0/0", sd_address, fifo_din, state_dbg);
    else passes++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_two_sectors();
    int eb, gb, rb, wb, db;
    bit ok0, ok1;
    eb = exp_q.size(); gb = got_q.size(); rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    fifo_data_count = 11'd0;
    pulse_play(32'h100, 16'd2, 1'b0);
    wait_rd(20, ok0); tick(1);
    serve(32'h100, 0, 512, -1, -1, 1'b1);
    wait_rd(20, ok1); tick(1);
    serve(32'h101, 0, 512, -1, -1, 1'b1);
    tick(6);
    checks++;
    if (!(ok0 && ok1) || rd_cnt - rb !== 2)
      $display("FAIL two_rd_count: got %0d expected 2", rd_cnt - rb);
    else passes++;
    checks++;
    if (addr_q.size() < rb + 2 || addr_q[rb] !== 32'h100 || addr_q[rb + 1] !== 32'h101)
      $display("FAIL two_addrs: got %0d entries expected 100,101", addr_q.size() - rb);
    else passes++;
    checks++;
    if (wr_cnt - wb !== 1024) $display("FAIL two_wr_count: got %0d expected 1024", wr_cnt - wb);
    else passes++;
    checks++;
    if (stream_errors(eb, gb) !== 0) $display("FAIL two_stream: got %0d bad bytes expected 0", stream_errors(eb, gb));
    else passes++;
    checks++;
    if (done_cnt - db !== 1 || busy !== 1'b0)
      $display("FAIL two_done: got done=%0d busy=%b expected 1/0", done_cnt - db, busy);
    else passes++;
  endtask

  task automatic test_fifo_space();
    int db;
    bit ok;
    db = done_cnt;
    fifo_data_count = 11'd600;
    pulse_play(32'h200, 16'd1, 1'b0);
    tick(20);
    checks++;
    if (state_dbg !== ST_WAIT_SPACE || addr_q.size() != rd_cnt || sd_rd !== 1'b0)
      $display("FAIL space_hold: got state=%0d expected %0d", state_dbg, ST_WAIT_SPACE);
    else passes++;
    fifo_data_count = 11'd512;
    wait_rd(3, ok); tick(1);
    checks++;
    if (!ok) $display("FAIL space_release: got no sd_rd expected sd_rd within 3 cycles");
    else passes++;
    serve(32'h200, 0, 512, -1, -1, 1'b1);
    tick(6);
    fifo_data_count = 11'd0;
    checks++;
    if (done_cnt - db !== 1) $display("FAIL space_done: got %0d expected 1", done_cnt - db);
    else passes++;
  endtask

  task automatic test_stop_mid_block();
    int eb, gb, rb, wb, db;
    bit ok;
    eb = exp_q.size(); gb = got_q.size(); rb = rd_cnt; wb = wr_cnt; db = done_cnt;
    pulse_play(32'h300, 16'd2, 1'b0);
    wait_rd(20, ok); tick(1);
    serve(32'h300, 0, 100, -1, -1, 1'b1);
    stop = 1'b1; tick(1); stop = 1'b0;
    serve(32'h300, 100, 411, -1, -1, 1'b0);
    checks++;
    if (state_dbg !== ST_DRAIN) $display("FAIL stop_drain: got state=%0d expected %0d", state_dbg, ST_DRAIN);
    else passes++;
    serve(32'h300, 511, 1, -1, -1, 1'b0);
    checks++;
    if (state_dbg !== ST_IDLE) $display("FAIL stop_idle: got state=%0d expected %0d", state_dbg, ST_IDLE);
    else passes++;
    tick(20);
    checks++;
    if (wr_cnt - wb !== 100 || stream_errors(eb, gb) !== 0)
      $display("FAIL stop_writes: got %0d expected 100", wr_cnt - wb);
    else passes++;
    checks++;
    if (rd_cnt - rb !== 1 || done_cnt - db !== 0)
      $display("FAIL stop_no_more: got rd=%0d done=%0d expected 1/0", rd_cnt - rb, done_cnt - db);
    else passes++;
  endtask

  task automatic test_overflow();
    int eb, gb, wb, db;
    bit ok;
    eb = exp_q.size(); gb = got_q.size(); wb = wr_cnt; db = done_cnt;
    pulse_play(32'h400, 16'd1, 1'b0);
    wait_rd(20, ok); tick(1);
    serve(32'h400, 0, 512, 10, 14, 1'b1);
    tick(6);
    checks++;
    if (wr_cnt - wb !== 507 || stream_errors(eb, gb) !== 0)
      $display("FAIL ovf_writes: got %0d expected 507", wr_cnt - wb);
    else passes++;
    checks++;
    if (done_cnt - db !== 1) $display("FAIL ovf_done: got %0d expected 1", done_cnt - db);
    else passes++;
    tick(10);
    checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow);
    else passes++;
    // New play clears the flag; hold it in WAIT_SPACE then stop it there.
    fifo_data_count = 11'd600;
    pulse_play(32'h500, 16'd1, 1'b0);
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b1)
      $display("FAIL ovf_clear: got overflow=%b busy=%b expected 0/1", overflow, busy);
    else passes++;
    db = done_cnt;
    stop = 1'b1; tick(1); stop = 1'b0;
    tick(5);
    checks++;
    if (state_dbg !== ST_IDLE || done_cnt - db !== 0)
      $display("FAIL stop_wait_space: got state=%0d done=%0d expected 0/0", state_dbg, done_cnt - db);
    else passes++;
    fifo_data_count = 11'd0;
  endtask

  task automatic test_reset_mid_block();
    int eb, gb, db;
    bit ok;
    pulse_play(32'h600, 16'd1, 1'b0);
    wait_rd(20, ok); tick(1);
    serve(32'h600, 0, 300, -1, -1, 1'b0);
    checks++;
    if (state_dbg !== ST_RECEIVE) $display("FAIL rst_pre_state: got %0d expected %0d", state_dbg, ST_RECEIVE);
    else passes++;
    #5 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, overflow, sd_rd, fifo_wr_en} !== 5'b0 || state_dbg !== ST_IDLE)
      $display("FAIL rst_async_flags: got %b state=%0d expected 00000/0", {busy, done, overflow, sd_rd, fifo_wr_en}, state_dbg);
    else passes++;
    checks++;
    if (sd_address !== 32'h0 || fifo_din !== 8'h0)
      $display("FAIL rst_async_regs: got addr=%0h din=%0h expected 0/0", sd_address, fifo_din);
    else passes++;
    #5 rst = 1'b0;
    eb = exp_q.size(); gb = got_q.size(); db = done_cnt;
    start_sector = 32'h20; num_sectors = 16'd1; play = 1'b1;
    tick(1);
    play = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL rst_first_play: got busy=%b expected 1", busy);
    else passes++;
    wait_rd(20, ok);
    checks++;
    if (!ok || sd_address !== 32'h20) $display("FAIL rst_new_addr: got %0h expected 20", sd_address);
    else passes++;
    tick(1);
    serve(32'h20, 0, 512, -1, -1, 1'b1);
    tick(6);
    checks++;
    if (done_cnt - db !== 1 || stream_errors(eb, gb) !== 0)
      $display("FAIL rst_new_block: got done=%0d bad=%0d expected 1/0", done_cnt - db, stream_errors(eb, gb));
    else passes++;
  endtask

  task automatic test_edge_cases();
    int rb, db;
    bit ok0, ok1;
    rb = rd_cnt; db = done_cnt;
    pulse_play(32'h700, 16'd0, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: got done=%b busy=%b expected 1/0", done, busy);
    else passes++;
    tick(4);
    checks++;
    if (done_cnt - db !== 1 || rd_cnt - rb !== 0)
      $display("FAIL zero_once: got done=%0d rd=%0d expected 1/0", done_cnt - db, rd_cnt - rb);
    else passes++;
    pulse_play(32'h700, 16'd1, 1'b1);
    checks++;
    if (busy !== 1'b0) $display("FAIL play_stop: got busy=%b expected 0", busy);
    else passes++;
    tick(5);
    checks++;
    if (busy !== 1'b0 || rd_cnt - rb !== 0) $display("FAIL play_stop_later: got busy=%b expected 0", busy);
    else passes++;
    db = done_cnt;
    pulse_play(32'hFFFF_FFFF, 16'd2, 1'b0);
    wait_rd(20, ok0); tick(1);
    serve(32'hFFFF_FFFF, 0, 512, -1, -1, 1'b1);
    wait_rd(20, ok1); tick(1);
    serve(32'h0, 0, 512, -1, -1, 1'b1);
    tick(6);
    checks++;
    if (!(ok0 && ok1) || addr_q.size() < rb + 2 || addr_q[rb] !== 32'hFFFF_FFFF || addr_q[rb + 1] !== 32'h0)
      $display("FAIL wrap_addrs: got %0d reads expected ffffffff,0", addr_q.size() - rb);
    else passes++;
    checks++;
    if (done_cnt - db !== 1 || busy !== 1'b0)
      $display("FAIL wrap_done: got done=%0d busy=%b expected 1/0", done_cnt - db, busy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_two_sectors();
    test_fifo_space();
    test_stop_mid_block();
    test_overflow();
    test_reset_mid_block();
    test_edge_cases();
    checks++;
    if (viol_cnt !== 0) $display("FAIL strobe_scope: got %0d out-of-state strobes expected 0", viol_cnt);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sd_stream_scheduler.md
SD_STREAM_SCHEDULER -- requirements
Module: sd_stream_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 1024, audio FIFO depth in bytes.
REQ-002 Parameter BLOCK_BYTES, default 512, bytes per SD sector read.
REQ-003 clk_25mhz  input  1  the single clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 play  input  1  one-cycle start pulse.
REQ-006 stop  input  1  one-cycle abort pulse.
REQ-007 start_sector  input  32  first sector address, latched on an accepted play.
REQ-008 num_sectors  input  16  sector count, latched on an accepted play.
REQ-009 sd_ready  input  1  SD controller is idle and can accept a read.
REQ-010 sd_byte_available  input  1  level; each rising edge marks one valid sd_dout byte.
REQ-011 sd_dout  input  8  SD read data byte.
REQ-012 sd_rd  output  1  read request to the SD controller.
REQ-013 sd_address  output  32  sector address for the SD controller.
REQ-014 fifo_data_count  input  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 fifo_full  input  1  FIFO full flag.
REQ-016 fifo_wr_en  output  1  FIFO write strobe.
REQ-017 fifo_din  output  8  FIFO write data.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse on normal completion.
REQ-020 overflow  output  1  sticky flag; cleared by rst or by an accepted play.

Function
REQ-021 States: IDLE, WAIT_SPACE, WAIT_READY, ISSUE, RECEIVE, NEXT, DRAIN.
REQ-022 IDLE: play with num_sectors != 0 latches the inputs, sets sector_idx=0, and goes to WAIT_SPACE.
- play with num_sectors == 0 pulses done on the next cycle and stays in IDLE.
- play while busy is ignored.
REQ-023 WAIT_SPACE: advance to WAIT_READY only when FIFO_DEPTH - fifo_data_count >= BLOCK_BYTES.
REQ-024 WAIT_READY: advance to ISSUE when sd_ready == 1.
REQ-025 ISSUE: drive sd_rd = 1 for exactly one cycle, with sd_address = latched start + sector_idx (32-bit wrap), then go to RECEIVE.
- sd_address holds its value until the next ISSUE.
REQ-026 RECEIVE: each rising edge of sd_byte_available (registered detect) produces one fifo_wr_en pulse the following cycle, with fifo_din = sd_dout sampled at the edge.
- Byte counter runs 0..BLOCK_BYTES-1.
- After byte BLOCK_BYTES-1, go to NEXT.
REQ-027 If fifo_full == 1 when a write is due: suppress fifo_wr_en, drop the byte, set overflow, and still count the byte.
REQ-028 NEXT: sector_idx += 1.
- If sector_idx == num_sectors-1, pulse done and go to IDLE.
- Otherwise go to WAIT_SPACE.
REQ-029 stop in IDLE, WAIT_SPACE or WAIT_READY: go to IDLE next cycle with no done pulse.
REQ-030 stop in ISSUE or RECEIVE: go to DRAIN. The in-flight SD block cannot be aborted.
REQ-031 DRAIN: keep counting the remaining byte edges with fifo_wr_en held 0; after BLOCK_BYTES total go to IDLE with no done pulse.
REQ-032 If play and stop arrive in the same cycle, stop wins; play is ignored.
REQ-033 fifo_wr_en is never asserted outside RECEIVE.
REQ-034 sd_rd is never asserted outside ISSUE.

Reset
REQ-035 On rst, asynchronously and regardless of state (including mid-block):
- state=IDLE.
- sd_rd=0, sd_address=0.
- fifo_wr_en=0, fifo_din=0.
- busy=0, done=0, overflow=0.
- All counters and the edge-detect register cleared.
REQ-036 After rst deasserts, the block accepts play on the first following clock edge.

Structure
REQ-037 Package sd_stream_pkg holds the state enum and the default BLOCK_BYTES constant.
REQ-038 One sub-module, rise_detect: a 1-bit registered rising-edge detector with async reset, used on sd_byte_available.
REQ-039 The block contains no FIFO and no SD protocol logic; it only sequences the SD controller and the FIFO.

Verification
REQ-040 play, start_sector=0x100, num_sectors=2, fifo_data_count=0:
- sd_rd pulses twice, with sd_address 0x100 then 0x101.
- 1024 fifo_wr_en pulses carry the model bytes in order.
- done pulses once; busy then falls.
REQ-041 fifo_data_count=600 (FIFO_DEPTH 1024), then play:
- No sd_rd while count > 512.
- Dropping the count to 512 yields sd_rd within 3 cycles.
REQ-042 stop after the 100th byte of sector 0:
- No further fifo_wr_en.
- The remaining 412 edges are consumed.
- State returns to IDLE; no done pulse; no second sd_rd.
REQ-043 fifo_full forced high for 5 byte edges:
- Exactly 5 writes missing.
- overflow=1 and it stays set until the next play.
- The block still completes with done.
REQ-044 rst asserted mid-RECEIVE (byte 300):
- All outputs are 0 immediately, before the next clock edge.
- A new play with start_sector=0x20 issues sd_address=0x20.
REQ-045 Edge cases:
- play with num_sectors=0 gives one done pulse and no sd_rd.
- play and stop in the same cycle give busy=0.
- start_sector=0xFFFFFFFF with num_sectors=2 gives addresses 0xFFFFFFFF then 0x00000000.
